// File: rtl/reg_writeback_queue.sv
// Write-back ordering queue in front of the 8x8 register file write port, with a pending-write scoreboard.
// Optional forwarding of the youngest pending value is built when REG_WB_FWD_EN is defined.
module reg_writeback_queue #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              aluValid,
  input  logic [ADDR_W-1:0] aluAddr,
  input  logic [DATA_W-1:0] aluData,
  input  logic              memValid,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] memData,
  input  logic [ADDR_W-1:0] queryAddr,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeAddr,
  output logic [DATA_W-1:0] writeData,
  output logic              pendingHit,
  output logic              fwdValid,
  output logic [DATA_W-1:0] fwdData,
  output logic              queueFull,
  output logic              overflowErr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addrQ [DEPTH];
  logic [DATA_W-1:0] dataQ [DEPTH];
  logic [PTR_W-1:0]  headPtr;
  logic [PTR_W-1:0]  tailPtr;
  logic [PTR_W-1:0]  aluSlot;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  pushCount;
  logic              pushMem;
  logic              pushAlu;
  logic              popHead;
  logic              overflowQ;

  // Full leaves room for a dual push, so an accepted cycle never enqueues only half its results
  assign queueFull = (count >= CNT_W'(DEPTH - 1));
  assign pushMem   = memValid & ~queueFull;
  assign pushAlu   = aluValid & ~queueFull;
  assign popHead   = (count != '0);
  assign pushCount = CNT_W'(pushMem) + CNT_W'(pushAlu);
  assign aluSlot   = pushMem ? tailPtr + PTR_W'(1) : tailPtr;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      headPtr   <= '0;
      tailPtr   <= '0;
      count     <= '0;
      overflowQ <= 1'b0;
    end else begin
      if (popHead) headPtr <= headPtr + PTR_W'(1);
      tailPtr <= tailPtr + pushCount[PTR_W-1:0];
      count   <= count + pushCount - CNT_W'(popHead);
      if ((memValid || aluValid) && queueFull) overflowQ <= 1'b1;
    end
  end

  // The load is the older instruction, so it takes the earlier slot
  always_ff @(posedge clock) begin
    if (resetN) begin
      if (pushMem) begin
        addrQ[tailPtr] <= memAddr;
        dataQ[tailPtr] <= memData;
      end
      if (pushAlu) begin
        addrQ[aluSlot] <= aluAddr;
        dataQ[aluSlot] <= aluData;
      end
    end
  end

  assign overflowErr = overflowQ;
  assign regWrite    = popHead;
  assign writeAddr   = popHead ? addrQ[headPtr] : '0;
  assign writeData   = popHead ? dataQ[headPtr] : '0;

  always_comb begin
    pendingHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (addrQ[headPtr + PTR_W'(i)] == queryAddr)) pendingHit = 1'b1;
    end
    if (memValid && (memAddr == queryAddr)) pendingHit = 1'b1;
    if (aluValid && (aluAddr == queryAddr)) pendingHit = 1'b1;
  end

`ifdef REG_WB_FWD_EN
  logic [DATA_W-1:0] queueFwd;

  // Scanning head to tail lets the tail-most match overwrite older ones
  always_comb begin
    queueFwd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (addrQ[headPtr + PTR_W'(i)] == queryAddr))
        queueFwd = dataQ[headPtr + PTR_W'(i)];
    end
  end

  always_comb begin
    fwdData = '0;
    if (aluValid && (aluAddr == queryAddr))      fwdData = aluData;
    else if (memValid && (memAddr == queryAddr)) fwdData = memData;
    else if (pendingHit)                         fwdData = queueFwd;
  end

  assign fwdValid = pendingHit;
`else
  assign fwdValid = 1'b0;
  assign fwdData  = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed self-checking bench for reg_writeback_queue (DEPTH=4); expectations adapt to REG_WB_FWD_EN.
module tb_reg_writeback_queue;

`ifdef REG_WB_FWD_EN
  localparam bit FwdOn = 1'b1;
`else
  localparam bit FwdOn = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetN;
  logic       aluValid, memValid;
  logic [2:0] aluAddr, memAddr, queryAddr;
  logic [7:0] aluData, memData;
  logic       regWrite, pendingHit, fwdValid, queueFull, overflowErr;
  logic [2:0] writeAddr;
  logic [7:0] writeData, fwdData;

  int checkCount = 0;
  int failCount  = 0;

  reg_writeback_queue #(.DATA_W(8), .ADDR_W(3), .DEPTH(4)) dut (
    .clock(clock), .resetN(resetN),
    .aluValid(aluValid), .aluAddr(aluAddr), .aluData(aluData),
    .memValid(memValid), .memAddr(memAddr), .memData(memData),
    .queryAddr(queryAddr),
    .regWrite(regWrite), .writeAddr(writeAddr), .writeData(writeData),
    .pendingHit(pendingHit), .fwdValid(fwdValid), .fwdData(fwdData),
    .queueFull(queueFull), .overflowErr(overflowErr)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic mv, input logic [2:0] ma, input logic [7:0] md,
                               input logic av, input logic [2:0] aa, input logic [7:0] ad);
    memValid = mv; memAddr = ma; memData = md;
    aluValid = av; aluAddr = aa; aluData = ad;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    resetN = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    resetN = 1'b1;
    #1;
  endtask

  initial begin
    queryAddr = 3'd0;
    doReset();
    checkOutput("rst_regWrite", 32'(regWrite), 0);
    checkOutput("rst_queueFull", 32'(queueFull), 0);
    checkOutput("rst_overflow", 32'(overflowErr), 0);
    checkOutput("rst_pending", 32'(pendingHit), 0);
    checkOutput("rst_writeData", 32'(writeData), 0);
    checkOutput("rst_fwdValid", 32'(fwdValid), 0);

    // single ALU result: commit one cycle after enqueue
    applyStimulus(0, 0, 0, 1, 3'd3, 8'h5A);
    queryAddr = 3'd3;
    #1;
    checkOutput("alu_pending_in", 32'(pendingHit), 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("alu_regWrite", 32'(regWrite), 1);
    checkOutput("alu_writeAddr", 32'(writeAddr), 3);
    checkOutput("alu_writeData", 32'(writeData), 32'h5A);
    checkOutput("alu_pending_q", 32'(pendingHit), 1);
    tick();
    checkOutput("alu_done_regWrite", 32'(regWrite), 0);
    checkOutput("alu_done_pending", 32'(pendingHit), 0);

    // dual push: load first, ALU second
    applyStimulus(1, 3'd1, 8'h11, 1, 3'd2, 8'h22);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("dual_addr0", 32'(writeAddr), 1);
    checkOutput("dual_data0", 32'(writeData), 32'h11);
    tick();
    checkOutput("dual_addr1", 32'(writeAddr), 2);
    checkOutput("dual_data1", 32'(writeData), 32'h22);
    tick();
    checkOutput("dual_idle", 32'(regWrite), 0);

    // three dual pushes back to back; third is dropped
    applyStimulus(1, 3'd4, 8'h41, 1, 3'd5, 8'h51);
    tick();
    checkOutput("ovf_full_c2", 32'(queueFull), 0);
    checkOutput("ovf_addr0", 32'(writeAddr), 4);
    applyStimulus(1, 3'd6, 8'h61, 1, 3'd7, 8'h71);
    tick();
    checkOutput("ovf_full_c3", 32'(queueFull), 1);
    checkOutput("ovf_addr1", 32'(writeAddr), 5);
    applyStimulus(1, 3'd0, 8'hEE, 1, 3'd1, 8'hEF);
    #1;
    checkOutput("ovf_err_before", 32'(overflowErr), 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("ovf_err_set", 32'(overflowErr), 1);
    checkOutput("ovf_full_after", 32'(queueFull), 0);
    checkOutput("ovf_addr2", 32'(writeAddr), 6);
    checkOutput("ovf_data2", 32'(writeData), 32'h61);
    tick();
    checkOutput("ovf_addr3", 32'(writeAddr), 7);
    checkOutput("ovf_data3", 32'(writeData), 32'h71);
    tick();
    checkOutput("ovf_drained", 32'(regWrite), 0);
    checkOutput("ovf_sticky", 32'(overflowErr), 1);

    doReset();
    checkOutput("ovf_cleared", 32'(overflowErr), 0);

    // duplicate destination r5 and scoreboard/forwarding
    applyStimulus(0, 0, 0, 1, 3'd5, 8'h10);
    tick();
    applyStimulus(0, 0, 0, 1, 3'd5, 8'h20);
    queryAddr = 3'd5;
    #1;
    checkOutput("dup_pending0", 32'(pendingHit), 1);
    checkOutput("dup_fwdValid0", 32'(fwdValid), FwdOn ? 1 : 0);
    checkOutput("dup_fwdData0", 32'(fwdData), FwdOn ? 32'h20 : 0);
    checkOutput("dup_write0", 32'(writeData), 32'h10);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("dup_pending1", 32'(pendingHit), 1);
    checkOutput("dup_write1", 32'(writeData), 32'h20);
    checkOutput("dup_fwdData1", 32'(fwdData), FwdOn ? 32'h20 : 0);
    tick();
    checkOutput("dup_pending_fall", 32'(pendingHit), 0);
    checkOutput("dup_regWrite_fall", 32'(regWrite), 0);

    // forwarding priority: ALU input > load input > tail-most queue entry
    applyStimulus(1, 3'd2, 8'h01, 1, 3'd2, 8'h02);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    queryAddr = 3'd2;
    #1;
    checkOutput("pri_queue", 32'(fwdData), FwdOn ? 32'h02 : 0);
    applyStimulus(1, 3'd2, 8'h03, 1, 3'd3, 8'h04);
    #1;
    checkOutput("pri_mem", 32'(fwdData), FwdOn ? 32'h03 : 0);
    applyStimulus(1, 3'd2, 8'h03, 1, 3'd2, 8'h05);
    #1;
    checkOutput("pri_alu", 32'(fwdData), FwdOn ? 32'h05 : 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("pri_drain0", 32'(writeData), 32'h02);
    tick();
    checkOutput("pri_drain1", 32'(writeData), 32'h03);
    tick();
    checkOutput("pri_drain2", 32'(writeData), 32'h05);
    tick();
    checkOutput("pri_drain_end", 32'(regWrite), 0);

    // reset while three entries are queued; input during reset ignored
    applyStimulus(1, 3'd4, 8'hA1, 1, 3'd5, 8'hA2);
    tick();
    applyStimulus(1, 3'd6, 8'hA3, 1, 3'd7, 8'hA4);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("mid_full", 32'(queueFull), 1);
    resetN = 1'b0;
    applyStimulus(0, 0, 0, 1, 3'd6, 8'h99);
    tick();
    resetN = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    queryAddr = 3'd6;
    #1;
    checkOutput("mid_regWrite", 32'(regWrite), 0);
    checkOutput("mid_queueFull", 32'(queueFull), 0);
    checkOutput("mid_pending", 32'(pendingHit), 0);
    checkOutput("mid_writeAddr", 32'(writeAddr), 0);
    tick();
    checkOutput("mid_no_commit", 32'(regWrite), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
